isq_dispatch: RTL and testbench

ISQ_DISPATCH -- requirements
Module: isq_dispatch

---
 rtl/isq_dispatch.sv | 114 +++++++++++
 tb/tb_isq_dispatch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/isq_dispatch.sv
// isq_dispatch: single-entry dispatch stage between rename and the issue queue.
// Holds one instruction in an output register and looks up a physical-register
// busy table to decide whether each source operand must sleep in the issue queue.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   rn2disp_valid/ready/data     rename -> dispatch handshake, packed instruction
//   flush                        drop held instruction, clear busy table
//   wb_valid, wb_prd             writeback completion (clears busy, wakes sleepers)
//   disp2isq_wren/wrdata         held instruction presented to the issue queue
//   disp2isq_sleep_rs1/rs2       source operand not yet produced
//   isq2disp_ready               issue queue has a free slot
//   stall_cnt                    free-running count of wren && !isq2disp_ready cycles
module isq_dispatch #(
  parameter int DATA_WIDTH = 248,
  parameter int PREG_NUM   = 64,
  localparam int TAG_W     = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rn2disp_valid,
  output logic                  rn2disp_ready,
  input  logic [DATA_WIDTH-1:0] rn2disp_data,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [TAG_W-1:0]      wb_prd,
  output logic                  disp2isq_wren,
  output logic [DATA_WIDTH-1:0] disp2isq_wrdata,
  output logic                  disp2isq_sleep_rs1,
  output logic                  disp2isq_sleep_rs2,
  input  logic                  isq2disp_ready,
  output logic [31:0]           stall_cnt
);

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_sleep1, hold_sleep2;
  logic [PREG_NUM-1:0]   busy;
  logic [PREG_NUM-1:0]   busy_nxt;

  // Field decode of the incoming word
  logic [TAG_W-1:0] in_prd, in_prs1, in_prs2;
  logic             in_need_wb, in_src1_reg, in_src2_reg;
  assign in_prd      = rn2disp_data[129:124];
  assign in_need_wb  = rn2disp_data[117];
  assign in_prs1     = rn2disp_data[116:111];
  assign in_prs2     = rn2disp_data[110:105];
  assign in_src1_reg = rn2disp_data[104];
  assign in_src2_reg = rn2disp_data[103];

  // Source tags of the held word, for wakeup while stalled
  logic [TAG_W-1:0] hold_prs1, hold_prs2;
  assign hold_prs1 = hold_data[116:111];
  assign hold_prs2 = hold_data[110:105];

  logic accept, drain;
  assign rn2disp_ready = !flush && (!hold_valid || isq2disp_ready);
  assign accept        = rn2disp_valid && rn2disp_ready;
  assign drain         = hold_valid && isq2disp_ready;

  // Load-time sleep: busy lookup with same-cycle writeback bypass
  logic load_sleep1, load_sleep2;
  assign load_sleep1 = in_src1_reg && busy[in_prs1] && !(wb_valid && wb_prd == in_prs1);
  assign load_sleep2 = in_src2_reg && busy[in_prs2] && !(wb_valid && wb_prd == in_prs2);

  // Busy update: writeback clears, accepted producer sets; set is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_prd] = 1'b0;
    if (accept && in_need_wb && in_prd != '0) busy_nxt[in_prd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      hold_sleep1 <= 1'b0;
      hold_sleep2 <= 1'b0;
      busy        <= '0;
    end else if (flush) begin
      hold_valid  <= 1'b0;
      hold_sleep1 <= 1'b0;
      hold_sleep2 <= 1'b0;
      busy        <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        hold_valid  <= 1'b1;
        hold_data   <= rn2disp_data;
        hold_sleep1 <= load_sleep1;
        hold_sleep2 <= load_sleep2;
      end else if (drain) begin
        hold_valid  <= 1'b0;
      end else if (hold_valid && wb_valid) begin
        // Sleep bits only ever clear while the word is stalled
        if (wb_prd == hold_prs1) hold_sleep1 <= 1'b0;
        if (wb_prd == hold_prs2) hold_sleep2 <= 1'b0;
      end
    end
  end

  // Wraps naturally at 2^32
  always_ff @(posedge clock) begin
    if (reset)                            stall_cnt <= '0;
    else if (hold_valid && !isq2disp_ready) stall_cnt <= stall_cnt + 32'd1;
  end

  assign disp2isq_wren      = hold_valid;
  assign disp2isq_wrdata    = hold_data;
  assign disp2isq_sleep_rs1 = hold_sleep1;
  assign disp2isq_sleep_rs2 = hold_sleep2;

endmodule

// File: tb/tb_isq_dispatch.sv
// Directed bench for isq_dispatch: reset state, dependency tracking through the
// busy table, writeback bypass/wakeup, stall counting, flush and mid-stall reset.
module tb_isq_dispatch;
  localparam int DW = 248;

  logic          clock = 1'b0;
  logic          reset;
  logic          rn2disp_valid;
  logic          rn2disp_ready;
  logic [DW-1:0] rn2disp_data;
  logic          flush;
  logic          wb_valid;
  logic [5:0]    wb_prd;
  logic          disp2isq_wren;
  logic [DW-1:0] disp2isq_wrdata;
  logic          disp2isq_sleep_rs1, disp2isq_sleep_rs2;
  logic          isq2disp_ready;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  isq_dispatch #(.DATA_WIDTH(DW), .PREG_NUM(64)) dut (
    .clock(clock), .reset(reset),
    .rn2disp_valid(rn2disp_valid), .rn2disp_ready(rn2disp_ready), .rn2disp_data(rn2disp_data),
    .flush(flush), .wb_valid(wb_valid), .wb_prd(wb_prd),
    .disp2isq_wren(disp2isq_wren), .disp2isq_wrdata(disp2isq_wrdata),
    .disp2isq_sleep_rs1(disp2isq_sleep_rs1), .disp2isq_sleep_rs2(disp2isq_sleep_rs2),
    .isq2disp_ready(isq2disp_ready), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [5:0] prd, input logic nwb,
                                        input logic [5:0] prs1, input logic [5:0] prs2,
                                        input logic s1, input logic s2, input logic [31:0] id);
    logic [DW-1:0] w;
    w = '0;
    w[129:124] = prd;
    w[117]     = nwb;
    w[116:111] = prs1;
    w[110:105] = prs2;
    w[104]     = s1;
    w[103]     = s2;
    w[31:0]    = id;
    w[247:216] = ~id;
    return w;
  endfunction

  task automatic offer(input logic [DW-1:0] w);
    rn2disp_valid = 1'b1;
    rn2disp_data  = w;
  endtask

  logic [DW-1:0] wa, wb, wd, wx, wn;

  initial begin
    reset = 1'b1; rn2disp_valid = 1'b0; rn2disp_data = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_prd = '0; isq2disp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_wren",   disp2isq_wren, 0);
    chk("rst_ready",  rn2disp_ready, 1);
    chk("rst_data",   disp2isq_wrdata, 0);
    chk("rst_sleep",  {disp2isq_sleep_rs1, disp2isq_sleep_rs2}, 0);
    chk("rst_stall",  stall_cnt, 0);

    // Producer A then dependent consumer B
    wa = mk(6'd5, 1, 6'd0, 6'd0, 0, 0, 32'hA);
    wb = mk(6'd0, 0, 6'd5, 6'd0, 1, 0, 32'hB);
    offer(wa); tick();
    chk("a_wren",  disp2isq_wren, 1);
    chk("a_data",  disp2isq_wrdata, wa);
    chk("a_sleep", {disp2isq_sleep_rs1, disp2isq_sleep_rs2}, 0);
    offer(wb); tick();
    chk("b_wren",  disp2isq_wren, 1);
    chk("b_data",  disp2isq_wrdata, wb);
    chk("b_sleep1", disp2isq_sleep_rs1, 1);
    rn2disp_valid = 1'b0; tick();
    chk("drain_wren", disp2isq_wren, 0);

    // Tag 0 never reads busy
    offer(mk(6'd0, 1, 6'd0, 6'd0, 0, 0, 32'hE)); tick();
    offer(mk(6'd0, 0, 6'd0, 6'd0, 1, 0, 32'hF)); tick();
    chk("p0_sleep1", disp2isq_sleep_rs1, 0);

    // Same-cycle writeback bypass on tag 7
    offer(mk(6'd7, 1, 6'd0, 6'd0, 0, 0, 32'h70)); tick();
    offer(mk(6'd0, 0, 6'd0, 6'd7, 0, 1, 32'hC)); wb_valid = 1'b1; wb_prd = 6'd7; tick();
    wb_valid = 1'b0;
    chk("c_sleep2", disp2isq_sleep_rs2, 0);
    offer(mk(6'd0, 0, 6'd0, 6'd7, 0, 1, 32'h71)); tick();
    chk("p7_cleared", disp2isq_sleep_rs2, 0);

    // Stall with wakeup of held D
    offer(mk(6'd9, 1, 6'd0, 6'd0, 0, 0, 32'h90)); tick();
    wd = mk(6'd0, 0, 6'd9, 6'd0, 1, 0, 32'hD);
    offer(wd); tick();
    chk("d_sleep1", disp2isq_sleep_rs1, 1);
    wx = mk(6'd11, 1, 6'd0, 6'd0, 0, 0, 32'h99);
    offer(wx); isq2disp_ready = 1'b0;
    #1 chk("st1_ready", rn2disp_ready, 0);
    tick();
    chk("st1_sleep", disp2isq_sleep_rs1, 1);
    chk("st1_data",  disp2isq_wrdata, wd);
    wb_valid = 1'b1; wb_prd = 6'd9;
    #1 chk("st2_ready", rn2disp_ready, 0);
    tick();
    wb_valid = 1'b0;
    chk("st2_sleep", disp2isq_sleep_rs1, 0);
    chk("st2_data",  disp2isq_wrdata, wd);
    #1 chk("st3_ready", rn2disp_ready, 0);
    tick();
    chk("st3_data",  disp2isq_wrdata, wd);
    chk("st3_stall", stall_cnt, 3);
    rn2disp_valid = 1'b0; isq2disp_ready = 1'b1; tick();
    chk("st_drain",  disp2isq_wren, 0);
    chk("st_hold",   stall_cnt, 3);

    // Set wins over same-cycle writeback on tag 12
    offer(mk(6'd12, 1, 6'd0, 6'd0, 0, 0, 32'hC0)); wb_valid = 1'b1; wb_prd = 6'd12; tick();
    wb_valid = 1'b0;
    offer(mk(6'd0, 0, 6'd12, 6'd0, 1, 0, 32'hC1)); tick();
    chk("p12_busy", disp2isq_sleep_rs1, 1);

    // Flush drops held word and busy bits, ignores offered input
    offer(mk(6'd3, 1, 6'd0, 6'd0, 0, 0, 32'h30)); tick();
    offer(mk(6'd0, 0, 6'd3, 6'd0, 1, 0, 32'h31)); flush = 1'b1;
    #1 chk("fl_ready", rn2disp_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_wren", disp2isq_wren, 0);
    wn = mk(6'd0, 0, 6'd3, 6'd12, 1, 1, 32'h32);
    offer(wn); tick();
    chk("fl_busy", {disp2isq_sleep_rs1, disp2isq_sleep_rs2}, 0);
    chk("fl_data", disp2isq_wrdata, wn);

    // Reset mid-stall discards held word
    rn2disp_valid = 1'b0; isq2disp_ready = 1'b0; tick();
    chk("rs_stall_pre", stall_cnt, 4);
    reset = 1'b1; tick();
    chk("rs_wren",  disp2isq_wren, 0);
    chk("rs_stall", stall_cnt, 0);
    reset = 1'b0; isq2disp_ready = 1'b1; tick();
    chk("rs_after", disp2isq_wren, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
